// File: rtl/alu_req_arbiter.sv
// -----------------------------------------------------------------------------
// alu_req_arbiter
//
// Lets two requesters share one external combinational ALU
// (and/or/xor/nor/add/sub/slt/sll).
//
// The block takes one operation at a time, drives it onto the ALU for a
// single cycle, and captures the result. It then holds that result on a
// shared response channel until the consumer accepts it. When both
// requesters are valid, the grant alternates between them.
//
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   req0_valid/ready/a/b/op   requester 0 valid/ready operation channel
//   req1_valid/ready/a/b/op   requester 1 valid/ready operation channel
//   alu_a, alu_b, alu_op      operands/opcode driven to the ALU
//   alu_f, alu_zf, alu_of     ALU result, zero flag, overflow flag
//   rsp_valid/ready           response handshake
//   rsp_id                    requester the response belongs to
//   rsp_f, rsp_zf, rsp_of     captured result and flags
//   busy                      high whenever an operation is in flight
//   op_count                  saturating count of completed responses
// -----------------------------------------------------------------------------
module alu_req_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_f,
  input  logic             alu_zf,
  input  logic             alu_of,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_f,
  output logic             rsp_zf,
  output logic             rsp_of,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [OPW-1:0] OP_ADD = OPW'(3'b100);
  localparam logic [OPW-1:0] OP_SUB = OPW'(3'b101);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic             prio;
  logic             grant0;
  logic             grant1;

  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic [OPW-1:0]   op_p0;
  logic             id_p0;

  logic             vld_p1;
  logic             id_p1;
  logic [WIDTH-1:0] f_p1;
  logic             zf_p1;
  logic             of_p1;
  logic [CNT_W-1:0] cnt_q;

  // The counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // ALU overflow is only meaningful for add/sub; it is garbage for every
  // other opcode and must not leak into the response.
  function automatic logic of_mask(input logic [OPW-1:0] op, input logic of);
    return of && ((op == OP_ADD) || (op == OP_SUB));
  endfunction

  // A single grant is picked combinationally and only in IDLE, so at most
  // one ready is high. On contention the requester named by prio wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && (!req1_valid || !prio)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      prio   <= 1'b0;
      a_p0   <= '0;
      b_p0   <= '0;
      op_p0  <= '0;
      id_p0  <= 1'b0;
      vld_p1 <= 1'b0;
      id_p1  <= 1'b0;
      f_p1   <= '0;
      zf_p1  <= 1'b0;
      of_p1  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      case (state)
        // ---- stage p0: accept and latch the granted operation ----
        // The latched operands feed the ALU directly, so they stay stable
        // until the next accept.
        IDLE: begin
          if (grant0 || grant1) begin
            a_p0  <= grant1 ? req1_a  : req0_a;
            b_p0  <= grant1 ? req1_b  : req0_b;
            op_p0 <= grant1 ? req1_op : req0_op;
            id_p0 <= grant1;
            prio  <= !grant1;
            state <= EXEC;
          end
        end
        // ---- stage p1: capture the ALU result ----
        EXEC: begin
          f_p1   <= alu_f;
          zf_p1  <= alu_zf;
          of_p1  <= of_mask(op_p0, alu_of);
          id_p1  <= id_p0;
          vld_p1 <= 1'b1;
          state  <= RESP;
        end
        // ---- response: hold until accepted ----
        // Returning to IDLE rather than regranting here means no accept can
        // share a cycle with the response handshake.
        RESP: begin
          if (rsp_ready) begin
            vld_p1 <= 1'b0;
            cnt_q  <= sat_inc(cnt_q);
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign alu_a      = a_p0;
  assign alu_b      = b_p0;
  assign alu_op     = op_p0;
  assign rsp_valid  = vld_p1;
  assign rsp_id     = id_p1;
  assign rsp_f      = f_p1;
  assign rsp_zf     = zf_p1;
  assign rsp_of     = of_p1;
  assign busy       = (state != IDLE);
  assign op_count   = cnt_q;

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares one combinational 32-bit multifunctional ALU between two requesters.
- The ALU performs and/or/xor/nor/add/sub/slt/sll.
- Each requester has a valid/ready request channel. Responses return on one shared valid/ready channel tagged with the requester id.
- Sits between the two requesting datapath units and the single ALU instance; drives the ALU A/B/ALU_OP inputs and samples F/ZF/OF.

Parameters:
- WIDTH, 32, operand/result width.
- OPW, 3, ALU_OP width (000 and, 001 or, 010 xor, 011 nor, 100 add, 101 sub, 110 slt, 111 sll B<<A[4:0]).
- CNT_W, 16, width of completed-operation counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a / req0_b  in  WIDTH  requester 0 operands.
- req0_op  in  OPW  requester 0 ALU_OP.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as above for requester 1.
- alu_a / alu_b  out  WIDTH  to ALU A/B.
- alu_op  out  OPW  to ALU ALU_OP.
- alu_f  in  WIDTH  ALU F.
- alu_zf  in  1  ALU ZF.
- alu_of  in  1  ALU OF.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester the response belongs to.
- rsp_f  out  WIDTH  result.
- rsp_zf  out  1  zero flag.
- rsp_of  out  1  overflow flag.
- busy  out  1  state != IDLE.
- op_count  out  CNT_W  completed operations, saturating.

Behaviour:
- Reset:
  - Asynchronous, active-high; takes effect immediately, mid-operation included.
  - state=IDLE, prio=0 (req0 preferred).
  - Operand/op regs = 0, so alu_a/alu_b/alu_op = 0.
  - rsp_valid=0, rsp_id=0, rsp_f=0, rsp_zf=0, rsp_of=0, busy=0, op_count=0.
  - Any in-flight operation is discarded; no response is issued for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = req0 if only req0_valid; req1 if only req1_valid; if both valid, the requester selected by prio.
  - reqN_ready = (state==IDLE) && grant==N. Combinational; at most one ready high per cycle; never high outside IDLE.
  - On grant: latch a/b/op and the grant id; set prio = !grant; go to EXEC.
  - No request: stay in IDLE.
- EXEC (one cycle):
  - alu_a/alu_b/alu_op driven from latched regs. These outputs are held stable from EXEC entry until the next accept.
  - At the clock edge, capture alu_f into rsp_f and alu_zf into rsp_zf.
  - Capture rsp_of = alu_of only when op is 100 or 101; otherwise rsp_of = 0 (ALU OF is undefined for the other ops).
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_id/rsp_f/rsp_zf/rsp_of held stable while rsp_ready=0 (backpressure for unlimited cycles).
  - On rsp_valid && rsp_ready: go to IDLE, rsp_valid falls next cycle, op_count += 1 (saturates at all-ones, no wrap).
  - A new request is not accepted in the same cycle as the response handshake.
- Latency: accept edge at cycle N, rsp_valid high from cycle N+2. Throughput: one op per 3 cycles with rsp_ready tied high.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1…
- A requester deasserting valid before ready is legal; nothing is latched.

Test Plan:
- Add overflow: req0 a=7FFF_0000, b=7FFF_0000, op=100 → rsp_id=0, rsp_f=FFFE_0000, rsp_zf=0, rsp_of=1; rsp_valid 2 cycles after req0_ready.
- Sub and masking: req1 a=1, b=2, op=101 → rsp_f=FFFF_FFFF, zf=0, of=0. Then req1 a=FFFF_0000, b=0000_FFFF, op=000 → rsp_f=0, zf=1, of=0 even with ALU model OF forced to 1.
- Arbitration: req0 and req1 both valid continuously after reset, rsp_ready=1 → accept order 0,1,0,1; rsp_id sequence 0,1,0,1; op_count=4 after four handshakes.
- Backpressure: shift a=4, b=0000_FFFF, op=111, rsp_ready=0 for 5 cycles → rsp_valid and rsp_f=000F_FFF0 held stable; req0_ready/req1_ready stay 0; handshake on cycle 6 then IDLE.
- Reset mid-EXEC: assert rst during EXEC → all outputs to reset values immediately, no response ever appears, op_count=0, and req0 has priority again.
- Saturation: with CNT_W=2, complete 5 operations → op_count=3.
